a5_1_stream_xor: RTL
====================

Name: a5_1_stream_xor

Overview:
- Byte-oriented XOR stage directly downstream of the A5/1 keystream generator (`cipher`).
- Takes the generator's 1-bit keystream plus a handshaked byte stream, and XORs each byte bit-serially, LSB first (bit 0 with the first keystream bit).
- Emits the result bytes on a handshaked output.
- Owns the generator's advance enable, so exactly 8 keystream bits are consumed per byte, never more. Used for both encrypt and decrypt.

Parameters:
- LEN_W, 16, width of the message byte count; 0 on len means 2^LEN_W bytes.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches len and begins a message; ignored unless state is IDLE.
- len  in  LEN_W  bytes in message; 0 means 2^LEN_W.
- ks_init  in  1  generator init_flag; 1 while the generator is still initializing.
- ks_bit  in  1  generator out_key; valid in any cycle where ks_en=1 and ks_init=0.
- ks_en  out  1  generator flag; generator advances one bit per clk while high.
- in_valid  in  1  input byte valid.
- in_ready  out  1  stage accepts a byte this cycle.
- in_data  in  8  plaintext or ciphertext byte.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  result byte.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted downstream.
- byte_cnt  out  LEN_W  bytes delivered downstream in current message.

Behaviour:
- Reset values: ks_en=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, byte_cnt=0. Internal plane=0, remaining=0, state=IDLE.
- IDLE -> WAIT_INIT on start.
- WAIT_INIT:
  - ks_en=0 and in_ready=0.
  - -> LOAD on the first cycle ks_init=0. If ks_init is already 0, the transition occurs one cycle after start.
- LOAD:
  - in_ready=1 iff the output register is empty, or is draining this cycle (out_valid & out_ready).
  - On in_valid & in_ready: work <= in_data, plane <= 0, -> MIX.
- MIX: 8 cycles, ks_en=1 in every one.
  - Each cycle: work[plane] <= work[plane] ^ ks_bit; plane <= plane+1.
  - When plane=7, the final XORed byte goes to out_data and out_valid <= 1. remaining decrements.
  - Next state: if remaining becomes 0 -> DRAIN, else -> LOAD.
  - The output register is guaranteed free here, because LOAD only accepts when it is free.
- DRAIN: wait for out_valid & out_ready on the last byte; done pulses on the next cycle; -> IDLE.
- Output register:
  - out_valid stays high until out_ready is seen; out_data is stable while out_valid & !out_ready.
  - byte_cnt increments on each output handshake and is cleared on start.
- Latency and throughput:
  - Input handshake at cycle t gives out_valid at t+8, i.e. the result is registered at the end of the 8th MIX cycle.
  - Throughput is 1 byte per 9 cycles with out_ready held high.
- ks_en invariants:
  - ks_en is high only in MIX, so total ks_en-high cycles per message = 8*len exactly.
  - Backpressure never advances the keystream.
- If ks_init rises during LOAD/MIX, this is a generator fault. Behaviour is undefined and need not be handled; the bench asserts it never occurs.
- start while busy: ignored; no change to len or counters.
- in_valid with in_ready=0: byte is not consumed; the source must hold it.
- rst mid-operation:
  - Next cycle, all outputs take their reset values and any partial byte is discarded.
  - The keystream position is not recoverable, so the generator must be reset or re-keyed together with this block.
- len=0: processes 2^LEN_W bytes; remaining is LEN_W+1 bits wide internally.

Test Plan:
- Single byte, ks_bit held 1: start, len=1, in_data=0x3C -> out_data=0xC3 at out_valid. ks_en high exactly 8 cycles; done pulses once the byte is accepted.
- LSB-first order: ks_bit=1 only in the first MIX cycle, in_data=0x00 -> 0x01. ks_bit=1 only in the 8th cycle -> 0x80.
- Init wait: ks_init held 1 for 20 cycles after start -> ks_en=0 and in_ready=0 throughout. The first in_ready occurs one cycle after ks_init falls.
- Backpressure: len=2, out_ready=0 for 10 cycles after the first out_valid. Expected:
  - out_data stable during the stall;
  - in_ready=0 and ks_en=0 during the stall;
  - total ks_en-high cycles = 16;
  - byte_cnt ends at 2.
- Reset mid-MIX: assert rst when plane=3 -> next cycle, all outputs are 0 and busy=0. A fresh start, len=1, 0xFF with ks_bit=0 -> 0xFF.
- Round trip with two `cipher` instances, both keyed pubk="hardware", prik=22'b1101001110000110010001. Encrypt 256 bytes 0x00..0xFF, then feed the ciphertext to the decrypt instance -> the output equals 0x00..0xFF in order. len=0 run (65536 bytes) -> done after byte_cnt wraps to 0.

Source files
------------

// File: rtl/a5_1_stream_xor.sv
//==============================================================================
// Module   : a5_1_stream_xor
// Purpose  : Bit-serial XOR of a handshaked byte stream with A5/1 keystream,
//            LSB first, consuming exactly 8 keystream bits per byte.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module a5_1_stream_xor #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             ks_init,
    input  logic             ks_bit,
    output logic             ks_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_LOAD      = 3'd2,
        S_MIX       = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_work;
    logic [2:0]       r_plane;
    logic [LEN_W:0]   r_remaining;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_done;
    logic [LEN_W-1:0] r_byte_cnt;

    logic             w_out_fire;
    logic             w_in_fire;
    logic             w_load_rdy;
    logic [7:0]       w_mixed;

    assign w_out_fire = r_out_valid & out_ready;
    assign w_load_rdy = ~r_out_valid | out_ready;
    assign w_in_fire  = (r_state == S_LOAD) & in_valid & w_load_rdy;

    always_comb begin
        w_mixed          = r_work;
        w_mixed[r_plane] = r_work[r_plane] ^ ks_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        ks_en    = 1'b0;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                if (!ks_init) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = w_load_rdy;
                if (in_valid && w_load_rdy) begin
                    w_next = S_MIX;
                end
            end
            S_MIX: begin
                ks_en = 1'b1;
                if (r_plane == 3'd7) begin
                    w_next = (r_remaining == (LEN_W+1)'(1)) ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (w_out_fire) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= 8'h00;
            r_plane     <= 3'd0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_done      <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_byte_cnt  <= r_byte_cnt + LEN_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // len==0 encodes a full 2^LEN_W-byte message
                        r_remaining <= (len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                                   : {1'b0, len};
                        r_byte_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_work  <= in_data;
                        r_plane <= 3'd0;
                    end
                end
                S_MIX: begin
                    r_work  <= w_mixed;
                    r_plane <= r_plane + 3'd1;
                    // Output register is always empty here: LOAD only accepts when it is free
                    if (r_plane == 3'd7) begin
                        r_out_data  <= w_mixed;
                        r_out_valid <= 1'b1;
                        r_remaining <= r_remaining - (LEN_W+1)'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign byte_cnt  = r_byte_cnt;

endmodule

`default_nettype wire
